// File: rtl/pwm_light_driver.sv
// ---------------------------------------------------------------------------
// pwm_light_driver : turns a 0..4 light level into a glitch-free PWM drive,
//                    with an optional stepped fade between duty levels.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pwm_light_driver #(
  parameter int unsigned CLK_DIV      = 100,
  parameter int unsigned PWM_BITS     = 8,
  parameter bit          FADE_EN      = 1'b1,
  parameter int unsigned STEP         = 16,
  parameter int unsigned RAMP_PERIODS = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [2:0]          i_lightState,
  output logic                o_pwm,
  output logic [PWM_BITS:0]   o_duty,
  output logic                o_busy,
  output logic                o_periodEnd
);

  localparam int DW = PWM_BITS + 1;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

  logic [2:0]          level;
  logic [PW-1:0]       prescale;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [RW-1:0]       ramp_cnt;
  logic [RW-1:0]       ramp_next;
  logic [DW-1:0]       duty;
  logic [DW-1:0]       duty_next;
  logic [DW-1:0]       target;
  logic                tick;
  logic                period_end;
  logic                pwm_q;
  logic                busy_q;
  logic                period_end_q;

  // Level 4 lands exactly on 2^PWM_BITS, which keeps the output solidly on.
  always_comb begin
    target = '0;
    if (level <= 3'd4) begin
      target = DW'(level) << (PWM_BITS - 2);
    end
  end

  assign tick       = (prescale == PW'(CLK_DIV - 1));
  assign period_end = tick && (pwm_cnt == {PWM_BITS{1'b1}});

  generate
    if (FADE_EN) begin : g_fade
      always_comb begin
        duty_next = duty;
        ramp_next = '0;
        if (duty != target) begin
          if (ramp_cnt != RW'(RAMP_PERIODS - 1)) begin
            ramp_next = ramp_cnt + 1'b1;
          end else if (target > duty) begin
            // Clamp the last step so the ramp lands on the target exactly.
            duty_next = (32'(target - duty) <= 32'(STEP)) ? target : duty + DW'(STEP);
          end else begin
            duty_next = (32'(duty - target) <= 32'(STEP)) ? target : duty - DW'(STEP);
          end
        end
      end
    end else begin : g_jump
      always_comb begin
        duty_next = target;
        ramp_next = '0;
      end
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      level        <= '0;
      prescale     <= '0;
      pwm_cnt      <= '0;
      ramp_cnt     <= '0;
      duty         <= '0;
      pwm_q        <= 1'b0;
      busy_q       <= 1'b0;
      period_end_q <= 1'b0;
    end else begin
      level <= i_lightState;
      if (tick) begin
        prescale <= '0;
        pwm_cnt  <= pwm_cnt + 1'b1;
      end else begin
        prescale <= prescale + 1'b1;
      end
      // Duty only moves on the period boundary so a pulse is never cut short.
      if (period_end) begin
        duty     <= duty_next;
        ramp_cnt <= ramp_next;
      end
      pwm_q        <= ({1'b0, pwm_cnt} < duty);
      busy_q       <= (duty != target);
      period_end_q <= period_end;
    end
  end

  assign o_pwm       = pwm_q;
  assign o_duty      = duty;
  assign o_busy      = busy_q;
  assign o_periodEnd = period_end_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_light_driver.sv
// ---------------------------------------------------------------------------
// tb_pwm_light_driver : directed scoreboard bench, one jump and one fade DUT.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pwm_light_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] lvl_a = '0;
  logic [2:0] lvl_b = '0;
  logic       pwm_a, busy_a, pe_a;
  logic       pwm_b, busy_b, pe_b;
  logic [4:0] duty_a, duty_b;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_t;

  sb_t sbq[$];

  always #5 clk = ~clk;

  pwm_light_driver #(
    .CLK_DIV(1), .PWM_BITS(4), .FADE_EN(1'b0), .STEP(4), .RAMP_PERIODS(1)
  ) u_jump (
    .i_clk(clk), .i_reset(rst), .i_lightState(lvl_a),
    .o_pwm(pwm_a), .o_duty(duty_a), .o_busy(busy_a), .o_periodEnd(pe_a)
  );

  pwm_light_driver #(
    .CLK_DIV(1), .PWM_BITS(4), .FADE_EN(1'b1), .STEP(4), .RAMP_PERIODS(1)
  ) u_fade (
    .i_clk(clk), .i_reset(rst), .i_lightState(lvl_b),
    .o_pwm(pwm_b), .o_duty(duty_b), .o_busy(busy_b), .o_periodEnd(pe_b)
  );

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return {31'b0, pwm_a};
      1:       return {27'b0, duty_a};
      2:       return {31'b0, busy_a};
      3:       return {31'b0, pe_a};
      4:       return {31'b0, pwm_b};
      5:       return {27'b0, duty_b};
      6:       return {31'b0, busy_b};
      default: return {31'b0, pe_b};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] e);
    sb_t s;
    s.tag = tag;
    s.sel = sel;
    s.exp = e;
    sbq.push_back(s);
  endtask

  task automatic sb_check();
    sb_t         s;
    logic [31:0] obs;
    while (sbq.size() > 0) begin
      s   = sbq.pop_front();
      obs = observe(s.sel);
      tests++;
      assert (obs === s.exp) else begin
        failed++;
        $error("FAIL %s at cyc %0d: observed=%0d expected=%0d", s.tag, cyc, obs, s.exp);
      end
    end
  endtask

  task automatic push_all_zero(input string tag);
    for (int i = 0; i < 8; i++) push(tag, i, 32'd0);
  endtask

  // One clock; period-end pulses land every 16 cycles after reset release.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    push("pe_a", 3, (cyc % 16 == 0) ? 32'd1 : 32'd0);
    push("pe_b", 7, (cyc % 16 == 0) ? 32'd1 : 32'd0);
  endtask

  // Asserts reset mid-cycle and checks the outputs clear before any edge.
  task automatic do_reset(input logic [2:0] a, input logic [2:0] b);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 push_all_zero("async_rst");
    sb_check();
    repeat (2) @(negedge clk);
    lvl_a = a;
    lvl_b = b;
    rst   = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    // Level 0 everywhere: no drive, no busy, periodic pulses.
    do_reset(3'd0, 3'd0);
    while (cyc < 64) begin
      step();
      push("idle_pwm_a", 0, 32'd0);
      push("idle_duty_a", 1, 32'd0);
      push("idle_busy_a", 2, 32'd0);
      push("idle_pwm_b", 4, 32'd0);
      push("idle_duty_b", 5, 32'd0);
      push("idle_busy_b", 6, 32'd0);
      sb_check();
    end

    // Jump DUT to level 2, fade DUT from 0 up to level 4.
    lvl_a = 3'd2;
    lvl_b = 3'd4;
    while (cyc < 144) begin
      step();
      if (cyc <= 80) push("jump_pwm_pre", 0, 32'd0);
      else push("jump_pwm", 0, ((cyc - 1) % 16 < 8) ? 32'd1 : 32'd0);
      if (cyc >= 80) push("jump_duty", 1, 32'd8);
      if (cyc >= 81) push("jump_busy", 2, 32'd0);
      if (cyc >= 80 && cyc % 16 == 0)
        push("fade_up_duty", 5, (cyc <= 128) ? 32'((cyc - 64) / 4) : 32'd16);
      if (cyc == 100) push("fade_up_busy_mid", 6, 32'd1);
      if (cyc >= 129) begin
        push("fade_full_busy", 6, 32'd0);
        push("fade_full_pwm", 4, 32'd1);
      end
      sb_check();
    end

    // Ramp to 12, then retarget down to level 1 mid-fade.
    do_reset(3'd0, 3'd4);
    while (cyc < 48) begin
      step();
      if (cyc % 16 == 0) push("ramp12_duty", 5, 32'(cyc / 4));
      sb_check();
    end
    lvl_b = 3'd1;
    while (cyc < 96) begin
      step();
      if (cyc == 64) push("rev_duty8", 5, 32'd8);
      if (cyc == 65) push("rev_busy", 6, 32'd1);
      if (cyc == 80 || cyc == 96) push("rev_duty4", 5, 32'd4);
      if (cyc >= 81) push("rev_busy_done", 6, 32'd0);
      sb_check();
    end

    // Back up to 8, then the illegal level 6 drains the duty to 0.
    lvl_b = 3'd2;
    while (cyc < 112) begin
      step();
      if (cyc == 112) push("to8_duty", 5, 32'd8);
      sb_check();
    end
    lvl_b = 3'd6;
    while (cyc < 145) begin
      step();
      if (cyc == 128) push("illegal_duty4", 5, 32'd4);
      if (cyc == 144) push("illegal_duty0", 5, 32'd0);
      if (cyc == 145) push("illegal_busy", 6, 32'd0);
      sb_check();
    end

    // Climb to 12, then reset partway into a period.
    lvl_b = 3'd3;
    while (cyc < 197) begin
      step();
      if (cyc == 160 || cyc == 176 || cyc == 192) push("to12_duty", 5, 32'((cyc - 144) / 4));
      if (cyc == 197) begin
        push("pre_rst_duty", 5, 32'd12);
        push("pre_rst_pwm", 4, 32'd1);
      end
      sb_check();
    end
    do_reset(3'd0, 3'd0);
    while (cyc < 20) begin
      step();
      push("post_rst_duty", 5, 32'd0);
      sb_check();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
